// File: rtl/frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : frame_reader
//  Description : Reads two camera FIFOs side by side (left half of each line
//                from cam1, right half from cam2) and emits RGB888 video with
//                hsync/vsync/de timing. Latches a sticky error on FIFO underflow
//                and blanks the rest of the affected frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_reader #(
    parameter int H_ACT  = 1280,
    parameter int H_FP   = 110,
    parameter int H_SYNC = 40,
    parameter int H_BP   = 220,
    parameter int V_ACT  = 720,
    parameter int V_FP   = 5,
    parameter int V_SYNC = 5,
    parameter int V_BP   = 20
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cam1_ready,
    input  logic        cam2_ready,
    input  logic        cam1_empty,
    input  logic        cam2_empty,
    input  logic [15:0] cam1_data,
    input  logic [15:0] cam2_data,
    output logic        read_en,
    output logic        cam_id,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        error
);

    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_ACT_C      = HW'(H_ACT);
    localparam logic [HW-1:0] H_HALF_C     = HW'(H_ACT / 2);
    localparam logic [HW-1:0] H_SYNC_FIRST = HW'(H_ACT + H_FP);
    localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_ACT + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] H_LAST       = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_ACT_C      = VW'(V_ACT);
    localparam logic [VW-1:0] V_SYNC_FIRST = VW'(V_ACT + V_FP);
    localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_ACT + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [VW-1:0]   vcnt_q, vcnt_d;

    // Stage 1: read strobe and timing flags for the current raster position
    logic            read_en_q, cam_id_q, hs1_q, vs1_q;
    // Stage 2: FIFO data arrives; remember which camera and whether to blank
    logic            de2_q, hs2_q, vs2_q, sel2_q, blank2_q;
    // Stage 3: output registers
    logic            de_q, hsync_q, vsync_q, error_q;
    logic [7:0]      r_q, g_q, b_q;

    logic            run, start, active, in_hsync, in_vsync, underflow;
    logic [15:0]     pix;

    assign run       = (state_q == RUN);
    assign start     = (state_q == WAIT) && cam1_ready && cam2_ready;
    assign active    = run && (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
    assign in_hsync  = (hcnt_q >= H_SYNC_FIRST) && (hcnt_q <= H_SYNC_LAST);
    assign in_vsync  = (vcnt_q >= V_SYNC_FIRST) && (vcnt_q <= V_SYNC_LAST);
    // The strobe is still issued on an empty FIFO; the FIFO ignores it.
    assign underflow = read_en_q && (cam_id_q ? cam2_empty : cam1_empty);
    assign pix       = sel2_q ? cam2_data : cam1_data;

    // Next state and raster counters; a spoiled frame ends in WAIT instead of wrapping.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        case (state_q)
            IDLE: begin
                state_d = WAIT;
                hcnt_d  = '0;
                vcnt_d  = '0;
            end
            WAIT: begin
                hcnt_d = '0;
                vcnt_d = '0;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (hcnt_q == H_LAST) begin
                    hcnt_d = '0;
                    if (vcnt_q == V_LAST) begin
                        vcnt_d = '0;
                        if (error_q || underflow) begin
                            state_d = WAIT;
                        end
                    end else begin
                        vcnt_d = vcnt_q + 1'b1;
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                hcnt_d  = '0;
                vcnt_d  = '0;
            end
        endcase
    end

    // State register and raster counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
        end
    end

    // Pixel pipeline: strobe/flags, then data-select tracking, then the output stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            read_en_q <= 1'b0;
            cam_id_q  <= 1'b0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            de2_q     <= 1'b0;
            hs2_q     <= 1'b0;
            vs2_q     <= 1'b0;
            sel2_q    <= 1'b0;
            blank2_q  <= 1'b0;
            de_q      <= 1'b0;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            r_q       <= 8'd0;
            g_q       <= 8'd0;
            b_q       <= 8'd0;
        end else begin
            read_en_q <= active;
            cam_id_q  <= active && (hcnt_q >= H_HALF_C);
            hs1_q     <= run && in_hsync;
            vs1_q     <= run && in_vsync;

            de2_q     <= read_en_q;
            hs2_q     <= hs1_q;
            vs2_q     <= vs1_q;
            sel2_q    <= cam_id_q;
            blank2_q  <= underflow || error_q;

            de_q      <= de2_q;
            hsync_q   <= hs2_q;
            vsync_q   <= vs2_q;
            if (de2_q && !blank2_q) begin
                r_q <= {pix[15:11], pix[15:13]};
                g_q <= {pix[10:5],  pix[10:9]};
                b_q <= {pix[4:0],   pix[4:2]};
            end else begin
                r_q <= 8'd0;
                g_q <= 8'd0;
                b_q <= 8'd0;
            end
        end
    end

    // Sticky underflow flag, cleared only when a new frame is started.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            error_q <= 1'b0;
        end else if (underflow) begin
            error_q <= 1'b1;
        end else if (start) begin
            error_q <= 1'b0;
        end
    end

    assign read_en = read_en_q;
    assign cam_id  = cam_id_q;
    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
    assign de      = de_q;
    assign r       = r_q;
    assign g       = g_q;
    assign b       = b_q;
    assign error   = error_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_reader
//  Description : Directed self-checking bench for frame_reader using a small
//                14x7 raster (8x4 active).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_reader;

    localparam int HT  = 14;   // clocks per line
    localparam int VT  = 7;    // lines per frame
    localparam int BIG = 32'h3FFF_FFFF;

    logic        clk;
    logic        rstn;
    logic        cam1_ready, cam2_ready, cam1_empty, cam2_empty;
    logic [15:0] cam1_data, cam2_data;
    logic        read_en, cam_id, hsync, vsync, de, error;
    logic [7:0]  r, g, b;

    int n_checks = 0;
    int n_errors = 0;
    int hs_cnt   = 0;
    int vs_cnt   = 0;
    int ovl_cnt  = 0;

    frame_reader #(
        .H_ACT(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACT(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cam1_ready (cam1_ready),
        .cam2_ready (cam2_ready),
        .cam1_empty (cam1_empty),
        .cam2_empty (cam2_empty),
        .cam1_data  (cam1_data),
        .cam2_data  (cam2_data),
        .read_en    (read_en),
        .cam_id     (cam_id),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .r          (r),
        .g          (g),
        .b          (b),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counter index c is active when inside the 8x4 window and before stop_c.
    function automatic bit act(input int c, input int stop_c);
        return (c >= 0) && (c < stop_c) && ((c % HT) < 8) && (((c / HT) % VT) < 4);
    endfunction

    // Checks one cycle, n edges after the start edge. read_en reflects counter
    // n-1, the video outputs reflect counter n-3. Pixels from bad_c onward are
    // blanked; counters stop existing at stop_c (FSM back in WAIT).
    task automatic check_cycle(input int n, input int bad_c, input int stop_c);
        int          c1, c3;
        bit          re_x, de_x, hs_x, vs_x, err_x, live;
        logic [31:0] rgb_x;
        c1    = n - 1;
        c3    = n - 3;
        re_x  = act(c1, stop_c);
        live  = (c3 >= 0) && (c3 < stop_c);
        de_x  = act(c3, stop_c);
        hs_x  = live && ((c3 % HT) >= 10) && ((c3 % HT) <= 11);
        vs_x  = live && (((c3 / HT) % VT) == 5);
        err_x = (n >= bad_c + 2);
        if (!de_x || c3 >= bad_c) rgb_x = 32'h0;
        else if ((c3 % HT) < 4)   rgb_x = 32'hFF0000;
        else                      rgb_x = 32'h00FF00;
        check($sformatf("read_en n=%0d", n), 32'(read_en), 32'(re_x));
        if (re_x) check($sformatf("cam_id n=%0d", n), 32'(cam_id), 32'((c1 % HT) >= 4));
        check($sformatf("de/hs/vs n=%0d", n), 32'({de, hsync, vsync}), 32'({de_x, hs_x, vs_x}));
        check($sformatf("rgb n=%0d", n), 32'({r, g, b}), rgb_x);
        check($sformatf("error n=%0d", n), 32'(error), 32'(err_x));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ctl"}, 32'({read_en, cam_id, hsync, vsync, de, error}), 32'h0);
        check({tag, " rgb"}, 32'({r, g, b}), 32'h0);
    endtask

    initial begin
        rstn       = 1'b0;
        cam1_ready = 1'b0;
        cam2_ready = 1'b0;
        cam1_empty = 1'b0;
        cam2_empty = 1'b0;
        cam1_data  = 16'hF800;   // pure red
        cam2_data  = 16'h07E0;   // pure green

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");

        // Only cam1 ready: nothing may start.
        @(posedge clk);
        #1 rstn = 1'b1;
        cam1_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check($sformatf("wait idle i=%0d", i), 32'({read_en, de, vsync}), 32'h0);
        end

        // Raise cam2_ready; the next edge starts the frame.
        // Two clean frames, then an underflow on line 1 pixel 5 of frame 3
        // (counter 215); readies drop at the same time and must be ignored.
        // Frame 3 ends at counter 293, so counters stop at 294.
        @(posedge clk);
        #1 cam2_ready = 1'b1;
        for (int n = 0; n <= 310; n++) begin
            @(posedge clk);
            #1;
            cam2_empty = (n == 216);
            if (n == 216) cam1_ready = 1'b0;
            @(negedge clk);
            check_cycle(n, 215, 294);
            if (n >= 3 && n < 3 + 2 * HT * VT) begin
                hs_cnt += int'(hsync);
                vs_cnt += int'(vsync);
                if (de && (hsync || vsync)) ovl_cnt++;
            end
        end
        check("hsync clocks in 2 frames", 32'(hs_cnt), 32'd28);
        check("vsync clocks in 2 frames", 32'(vs_cnt), 32'd28);
        check("de overlapping sync", 32'(ovl_cnt), 32'd0);

        // Restart from WAIT: error must clear on the start edge.
        @(posedge clk);
        #1 cam1_ready = 1'b1;
        for (int m = 0; m <= 36; m++) begin
            @(posedge clk);
            @(negedge clk);
            check_cycle(m, BIG, BIG);
        end

        // Outputs now show line 2 pixel 5; reset clears everything at once.
        #1 rstn = 1'b0;
        #1 check_all_zero("async reset");
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check_all_zero("after release idle");
        @(posedge clk);
        @(negedge clk);
        check_all_zero("after release wait");
        for (int k = 0; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_cycle(k, BIG, BIG);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
